data_memory_lsu: RTL and testbench

DATA_MEMORY_LSU -- requirements
Module: data_memory_lsu

---
 rtl/data_memory_pkg.sv | 17 +
 rtl/dm_lane_fmt.sv | 52 +++++
 rtl/data_memory_lsu.sv | 117 +++++++++++
 tb/tb_data_memory_lsu.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared types for the data memory load/store unit.
// Access size encoding and FSM states.
package data_memory_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_e;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_e;

endpackage

// File: rtl/dm_lane_fmt.sv
// Byte-lane formatting for the LSU: store enables and data replication,
// load extraction and extension, plus misalignment detection.
module dm_lane_fmt
   import data_memory_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  off_i,
   input  logic        uns_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic        err_o,
   output logic [3:0]  be_o,
   output logic [31:0] wrep_o,
   output logic [31:0] rdata_o
);

   size_e       sz;
   logic [31:0] sh;

   assign sz = size_e'(size_i);
   assign sh = rword_i >> {off_i, 3'b000};

   always_comb begin
      err_o   = 1'b0;
      be_o    = 4'b0000;
      wrep_o  = wdata_i;
      rdata_o = rword_i;
      unique case (sz)
         SZ_BYTE: begin
            be_o    = 4'b0001 << off_i;
            wrep_o  = {4{wdata_i[7:0]}};
            rdata_o = {{24{~uns_i & sh[7]}}, sh[7:0]};
         end
         SZ_HALF: begin
            err_o   = off_i[0];
            be_o    = off_i[0] ? 4'b0000
                    : (off_i[1] ? 4'b1100 : 4'b0011);
            wrep_o  = {2{wdata_i[15:0]}};
            rdata_o = {{16{~uns_i & sh[15]}}, sh[15:0]};
         end
         SZ_WORD: begin
            err_o = |off_i;
            be_o  = err_o ? 4'b0000 : 4'b1111;
         end
         SZ_ILL: begin
            err_o   = 1'b1;
            rdata_o = 32'd0;
         end
      endcase
   end

endmodule

// File: rtl/data_memory_lsu.sv
// Word-organised data memory with a byte-lane load/store front end
// and a power-on initialisation sweep.
module data_memory_lsu
   import data_memory_pkg::*;
#(
   parameter int DEPTH     = 256,
   parameter int INIT_MODE = 1,
   parameter int PROBE_IDX = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        init_busy,
   output logic [31:0] probe
);

   localparam int            AW   = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   localparam logic [AW-1:0] PIDX = AW'(PROBE_IDX);

   logic [31:0]   mem_q [DEPTH];
   state_e        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          rsp_valid_q, rsp_err_q;
   logic [31:0]   rsp_rdata_q, rsp_rdata_d;

   logic          accept, init_we, err;
   logic [3:0]    be;
   logic [31:0]   wrep, ldata;
   logic [AW-1:0] widx;
   logic          unused_addr;

   // Upper address bits are dropped so accesses wrap around the array.
   assign widx        = req_addr[AW+1:2];
   assign unused_addr = ^req_addr[31:AW+2];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         ST_INIT: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST) state_d = ST_READY;
         end
         ST_READY: idx_d = '0;
      endcase
   end

   always_comb begin
      req_ready = rst_n && (state_q == ST_READY);
      init_busy = !rst_n || (state_q == ST_INIT);
      init_we   = rst_n && (state_q == ST_INIT);
   end

   assign accept = req_valid & req_ready;

   dm_lane_fmt u_fmt (
      .size_i  (req_size),
      .off_i   (req_addr[1:0]),
      .uns_i   (req_unsigned),
      .wdata_i (req_wdata),
      .rword_i (mem_q[widx]),
      .err_o   (err),
      .be_o    (be),
      .wrep_o  (wrep),
      .rdata_o (ldata)
   );

   always_ff @(posedge clk) begin
      if (init_we) begin
         mem_q[idx_q] <= (INIT_MODE != 0) ? 32'(idx_q) : 32'd0;
      end else if (accept && req_we) begin
         for (int k = 0; k < 4; k++) begin
            if (be[k]) mem_q[widx][8*k +: 8] <= wrep[8*k +: 8];
         end
      end
   end

   assign rsp_rdata_d = (req_we || err) ? 32'd0 : ldata;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'd0;
      end else begin
         rsp_valid_q <= accept;
         rsp_err_q   <= accept & err;
         rsp_rdata_q <= accept ? rsp_rdata_d : 32'd0;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign probe     = mem_q[PIDX];

endmodule

// File: tb/tb_data_memory_lsu.sv
// Scoreboard bench for data_memory_lsu: directed requests push
// expected responses, a negedge monitor pops and compares.
module tb_data_memory_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err, init_busy;
   logic [31:0] rsp_rdata, probe;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      string       name;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   run    = 0;
   int   cnt;

   always #5 clk = ~clk;

   data_memory_lsu dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .init_busy    (init_busy),
      .probe        (probe)
   );

   always @(negedge clk) begin
      if (rsp_valid) begin
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp: got err=%b rdata=%h, none expected",
                     rsp_err, rsp_rdata);
         end else begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin
               errors++;
               $display("FAIL %s: got err=%b rdata=%h expected err=%b rdata=%h",
                        e.name, rsp_err, rsp_rdata, e.err, e.rdata);
            end
         end
      end
      run = rsp_valid ? run + 1 : 0;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] wd, input logic xerr,
                       input logic [31:0] xrd, input string name);
      exp_t e;
      @(negedge clk);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wd;
      e.err   = xerr;
      e.rdata = xrd;
      e.name  = name;
      q.push_back(e);
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL rsp_timeout: got %0d pending, expected 0", q.size());
         q.delete();
      end
   endtask

   task automatic count_init(output int n);
      n = 0;
      while (init_busy && n < 1000) begin
         n++;
         @(negedge clk);
      end
      req_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n        = 1'b0;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'b10;
      req_unsigned = 1'b0;
      req_addr     = 32'd0;
      req_wdata    = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(init_busy), 32'd1);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_err", 32'(rsp_err), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      rst_n = 1'b1;
      count_init(cnt);
      chk("init_cycles", cnt, 32'd256);
      chk("ready_after", 32'(req_ready), 32'd1);
      chk("probe_init", probe, 32'h2);

      send(0, 2'b10, 0, 32'h0C, 0, 0, 32'h3, "ld_0c");
      send(1, 2'b10, 0, 32'h40, 32'hAABBCCDD, 0, 0, "st_w40");
      send(1, 2'b00, 0, 32'h42, 32'hFFFFFF11, 0, 0, "st_b42");
      send(0, 2'b10, 0, 32'h40, 0, 0, 32'hAA11CCDD, "ld_w40");
      send(0, 2'b01, 0, 32'h42, 0, 0, 32'hFFFFAA11, "ld_hs42");
      send(0, 2'b01, 1, 32'h42, 0, 0, 32'h0000AA11, "ld_hu42");
      send(0, 2'b00, 0, 32'h43, 0, 0, 32'hFFFFFFAA, "ld_bs43");
      send(0, 2'b00, 1, 32'h40, 0, 0, 32'h000000DD, "ld_bu40");
      send(1, 2'b10, 0, 32'h41, 32'h55555555, 1, 0, "st_mis41");
      send(0, 2'b10, 0, 32'h40, 0, 0, 32'hAA11CCDD, "ld_w40_kept");
      send(0, 2'b11, 0, 32'h40, 0, 1, 0, "ld_ill");
      send(0, 2'b01, 0, 32'h41, 0, 1, 0, "ld_hmis");
      send(1, 2'b01, 0, 32'h0A, 32'h0000BEEF, 0, 0, "st_h0a");
      @(negedge clk);
      req_valid = 1'b0;
      chk("probe_store", probe, 32'hBEEF0002);
      drain();

      send(1, 2'b10, 0, 32'h400, 32'hDEADBEEF, 0, 0, "st_wrap");
      send(0, 2'b10, 0, 32'h0, 0, 0, 32'hDEADBEEF, "ld_b2b");
      idle();
      #1;
      chk("b2b_run", run, 32'd2);
      drain();

      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      rst_n = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_size  = 2'b10;
      req_addr  = 32'h08;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      count_init(cnt);
      chk("reinit_cycles", cnt, 32'd256);
      chk("reinit_probe", probe, 32'h2);
      send(0, 2'b10, 0, 32'h08, 0, 0, 32'h2, "ld_08_reinit");
      send(0, 2'b10, 0, 32'h00, 0, 0, 32'h0, "ld_00_reinit");
      idle();
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
